cdb_arbiter: RTL and testbench



---
 rtl/cdb_arbiter_pkg.sv | 27 ++
 rtl/cdb_arbiter_if.sv | 27 ++
 rtl/cdb_fifo.sv | 70 +++++++
 rtl/cdb_arbiter.sv | 91 +++++++++
 tb/tb_cdb_arbiter.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared types for the Common Data Bus arbiter: producer ids, the execute
// write-back packet, and the round-robin pointer helper.
package cdb_arbiter_pkg;

   typedef enum logic [1:0] {
      CDB_ALU   = 2'd0,
      CDB_MULT  = 2'd1,
      CDB_STORE = 2'd2,
      CDB_LOAD  = 2'd3
   } CDB_SRC;

   localparam int NUM_CDB_SRC = 4;
   localparam int ROB_TAG_W   = 5;

   typedef struct packed {
      logic                 valid;
      logic [ROB_TAG_W-1:0] rob_tag;
      logic [31:0]          value;
      logic [31:0]          inst;
      logic [31:0]          npc;
   } EX_WR_PACKET;

   function automatic int rr_next(input int idx, input int n);
      return (idx + 1) % n;
   endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Producer-to-CDB bundle: per-source packets and stalls in, one broadcast out.
interface cdb_arbiter_if
   import cdb_arbiter_pkg::*;
#(
   parameter int NUM_SRC = NUM_CDB_SRC
) ();

   localparam int SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

   logic                      flush;
   EX_WR_PACKET [NUM_SRC-1:0] src_packet;
   logic [NUM_SRC-1:0]        src_stall;
   EX_WR_PACKET               cdb_packet;
   logic [SW-1:0]             cdb_src;
   logic                      overflow;

   modport master (
      output flush, src_packet,
      input  src_stall, cdb_packet, cdb_src, overflow
   );

   modport slave (
      input  flush, src_packet,
      output src_stall, cdb_packet, cdb_src, overflow
   );

endinterface

// File: rtl/cdb_fifo.sv
// Per-producer result FIFO with wrap-around pointers, registered-count stall,
// and a one-cycle pulse whenever an incoming packet has to be dropped.
module cdb_fifo
   import cdb_arbiter_pkg::*;
#(
   parameter  int DEPTH        = 4,
   parameter  int STALL_MARGIN = 1,
   localparam int CW           = $clog2(DEPTH + 1),
   localparam int PW           = $clog2(DEPTH)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          flush,
   input  logic          push,
   input  EX_WR_PACKET   push_data,
   input  logic          pop,
   output EX_WR_PACKET   head,
   output logic          empty,
   output logic [CW-1:0] count,
   output logic          stall,
   output logic          overflow_pulse
);

   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   EX_WR_PACKET   mem [DEPTH];
   logic [PW-1:0] head_ptr;
   logic [PW-1:0] tail_ptr;
   logic          do_pop;
   logic          do_push;

   function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // A full FIFO still accepts when its head leaves in the same cycle.
   assign do_pop         = pop && !empty;
   assign do_push        = push && !flush && ((count != FULL_COUNT) || do_pop);
   assign overflow_pulse = push && !flush && (count == FULL_COUNT) && !do_pop;
   assign empty          = (count == '0);
   assign head           = mem[head_ptr];
   assign stall          = (DEPTH - int'(count)) <= STALL_MARGIN;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         head_ptr <= '0;
         tail_ptr <= '0;
         count    <= '0;
      end else if (flush) begin
         head_ptr <= '0;
         tail_ptr <= '0;
         count    <= '0;
      end else begin
         if (do_push) tail_ptr <= wrap_inc(tail_ptr);
         if (do_pop)  head_ptr <= wrap_inc(head_ptr);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // NOTE: storage is not reset; count gates every read, so stale entries never reach the bus.
   always_ff @(posedge clock) begin
      if (do_push) mem[tail_ptr] <= push_data;
   end

endmodule

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: one FIFO per producer, round-robin broadcast of
// one result per cycle, sticky overflow flag, flush squashes everything.
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int NUM_SRC      = NUM_CDB_SRC,
   parameter int FIFO_DEPTH   = 4,
   parameter int STALL_MARGIN = 1
) (
   input logic          clock,
   input logic          reset,
   cdb_arbiter_if.slave bus
);

   localparam int SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   EX_WR_PACKET        head [NUM_SRC];
   logic [NUM_SRC-1:0] empty;
   logic [NUM_SRC-1:0] pop;
   logic [NUM_SRC-1:0] ovf_pulse;
   logic [SW-1:0]      rr_ptr;
   logic [SW-1:0]      winner;
   logic [SW-1:0]      idx;
   logic               found;
   logic               overflow_q;

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      logic [CW-1:0] count;

      cdb_fifo #(
         .DEPTH        (FIFO_DEPTH),
         .STALL_MARGIN (STALL_MARGIN)
      ) u_fifo (
         .clock          (clock),
         .reset          (reset),
         .flush          (bus.flush),
         .push           (bus.src_packet[i].valid),
         .push_data      (bus.src_packet[i]),
         .pop            (pop[i]),
         .head           (head[i]),
         .empty          (empty[i]),
         .count          (count),
         .stall          (bus.src_stall[i]),
         .overflow_pulse (ovf_pulse[i])
      );

      a_count_bound : assert property (@(posedge clock) disable iff (!reset)
         count <= CW'(FIFO_DEPTH));
   end

   // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
   always_comb begin
      found  = 1'b0;
      winner = '0;
      idx    = '0;
      pop    = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         idx = SW'((int'(rr_ptr) + k) % NUM_SRC);
         if (!found && !empty[idx]) begin
            found  = 1'b1;
            winner = idx;
         end
      end
      if (found) pop[winner] = 1'b1;
   end

   always_comb begin
      bus.cdb_packet = '0;
      bus.cdb_src    = '0;
      if (found) begin
         bus.cdb_packet       = head[winner];
         bus.cdb_packet.valid = 1'b1;
         bus.cdb_src          = winner;
      end
   end

   // A flush squashes the broadcast, so the fairness pointer must not advance.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rr_ptr     <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (found && !bus.flush) rr_ptr <= SW'(rr_next(int'(winner), NUM_SRC));
         if (|ovf_pulse)          overflow_q <= 1'b1;
      end
   end

   assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: per-source scoreboard queues are filled as packets are
// driven and drained as the bus grants them, predicting every broadcast.
module tb_cdb_arbiter;
   import cdb_arbiter_pkg::*;

   localparam int N      = NUM_CDB_SRC;
   localparam int DEPTH  = 4;
   localparam int MARGIN = 1;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   cdb_arbiter_if #(.NUM_SRC(N)) bus ();

   cdb_arbiter #(
      .NUM_SRC      (N),
      .FIFO_DEPTH   (DEPTH),
      .STALL_MARGIN (MARGIN)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   int          n_tests = 0;
   int          n_fail  = 0;
   int          tag_seq = 0;
   EX_WR_PACKET sb_q [N][$];
   int          m_rr    = 0;
   logic        m_ovf   = 1'b0;

   function automatic EX_WR_PACKET make_pkt(input int tag, input logic [31:0] value);
      EX_WR_PACKET p;
      p.valid   = 1'b1;
      p.rob_tag = ROB_TAG_W'(tag);
      p.value   = value;
      p.inst    = 32'hB000_0000 | value;
      p.npc     = value + 32'd4;
      return p;
   endfunction

   function automatic EX_WR_PACKET next_pkt();
      tag_seq++;
      return make_pkt(tag_seq, 32'h1000 + 32'(tag_seq) * 32'h11);
   endfunction

   function automatic int m_winner();
      for (int k = 0; k < N; k++)
         if (sb_q[(m_rr + k) % N].size() > 0) return (m_rr + k) % N;
      return -1;
   endfunction

   function automatic EX_WR_PACKET exp_cdb();
      int w;
      EX_WR_PACKET p;
      w = m_winner();
      p = '0;
      if (w >= 0) begin
         p       = sb_q[w][0];
         p.valid = 1'b1;
      end
      return p;
   endfunction

   function automatic logic [1:0] exp_src();
      int w;
      w = m_winner();
      return (w >= 0) ? 2'(w) : 2'd0;
   endfunction

   function automatic logic [N-1:0] exp_stall();
      logic [N-1:0] s;
      for (int i = 0; i < N; i++) s[i] = (DEPTH - sb_q[i].size()) <= MARGIN;
      return s;
   endfunction

   task automatic clear_inputs();
      bus.src_packet = '0;
      bus.flush      = 1'b0;
   endtask

   task automatic present(input int src);
      bus.src_packet[src] = next_pkt();
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) sb_q[i].delete();
      m_rr  = 0;
      m_ovf = 1'b0;
   endtask

   // Commits the current inputs to the model, then advances one clock edge.
   task automatic step();
      int w;
      w = m_winner();
      if (bus.flush) begin
         for (int i = 0; i < N; i++) sb_q[i].delete();
      end else begin
         if (w >= 0) begin
            void'(sb_q[w].pop_front());
            m_rr = (w + 1) % N;
         end
         for (int i = 0; i < N; i++) begin
            if (bus.src_packet[i].valid) begin
               if (sb_q[i].size() < DEPTH) sb_q[i].push_back(bus.src_packet[i]);
               else m_ovf = 1'b1;
            end
         end
      end
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      clear_inputs();
      model_reset();
      repeat (2) @(posedge clock);
      #1;
      n_tests++;
      if (bus.cdb_packet !== '0 || bus.cdb_src !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_cdb: src=%0d pkt=%h, expected src=0 pkt=0", bus.cdb_src, bus.cdb_packet);
      end
      n_tests++;
      if (bus.src_stall !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_stall: got %b, expected 0000", bus.src_stall);
      end
      n_tests++;
      if (bus.overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_overflow: got %b, expected 0", bus.overflow);
      end
      reset = 1'b1;
      step();
      n_tests++;
      if (bus.cdb_packet.valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_idle: valid=%b, expected 0", bus.cdb_packet.valid);
      end
   endtask

   task automatic test_single_alu();
      bus.src_packet[int'(CDB_ALU)] = make_pkt(5, 32'h10);
      step();
      clear_inputs();
      n_tests++;
      if (bus.cdb_packet !== exp_cdb() || bus.cdb_src !== exp_src()) begin
         n_fail++;
         $display("FAIL alu_model: src=%0d pkt=%h, expected src=%0d pkt=%h", bus.cdb_src, bus.cdb_packet, exp_src(), exp_cdb());
      end
      n_tests++;
      if (bus.cdb_packet.valid !== 1'b1 || bus.cdb_packet.rob_tag !== 5'd5 ||
          bus.cdb_packet.value !== 32'h10 || bus.cdb_src !== 2'd0) begin
         n_fail++;
         $display("FAIL alu_fields: valid=%b tag=%0d value=%h src=%0d, expected 1/5/10/0",
                  bus.cdb_packet.valid, bus.cdb_packet.rob_tag, bus.cdb_packet.value, bus.cdb_src);
      end
      step();
      n_tests++;
      if (bus.cdb_packet.valid !== 1'b0) begin
         n_fail++;
         $display("FAIL alu_idle: valid=%b, expected 0", bus.cdb_packet.valid);
      end
   endtask

   task automatic test_all_sources();
      // A lone LOAD grant parks the round-robin pointer back at ALU.
      present(int'(CDB_LOAD));
      step();
      clear_inputs();
      n_tests++;
      if (bus.cdb_packet !== exp_cdb() || bus.cdb_src !== 2'd3) begin
         n_fail++;
         $display("FAIL load_park: src=%0d pkt=%h, expected src=3 pkt=%h", bus.cdb_src, bus.cdb_packet, exp_cdb());
      end
      step();
      for (int i = 0; i < N; i++) present(i);
      step();
      clear_inputs();
      for (int k = 0; k < N; k++) begin
         n_tests++;
         if (bus.cdb_packet !== exp_cdb() || bus.cdb_src !== 2'(k)) begin
            n_fail++;
            $display("FAIL all_src_order[%0d]: src=%0d pkt=%h, expected src=%0d pkt=%h",
                     k, bus.cdb_src, bus.cdb_packet, k, exp_cdb());
         end
         step();
      end
      n_tests++;
      if (bus.cdb_packet.valid !== 1'b0) begin
         n_fail++;
         $display("FAIL all_src_idle: valid=%b, expected 0", bus.cdb_packet.valid);
      end
      present(int'(CDB_ALU));
      present(int'(CDB_LOAD));
      step();
      clear_inputs();
      for (int k = 0; k < 2; k++) begin
         n_tests++;
         if (bus.cdb_packet !== exp_cdb() || bus.cdb_src !== ((k == 0) ? 2'd0 : 2'd3)) begin
            n_fail++;
            $display("FAIL rr_wrap[%0d]: src=%0d pkt=%h, expected src=%0d pkt=%h",
                     k, bus.cdb_src, bus.cdb_packet, (k == 0) ? 0 : 3, exp_cdb());
         end
         step();
      end
   endtask

   task automatic test_store_stream();
      present(int'(CDB_STORE));
      step();
      for (int i = 1; i <= 8; i++) begin
         if (i < 8) present(int'(CDB_STORE));
         else clear_inputs();
         n_tests++;
         if (bus.cdb_packet !== exp_cdb() || bus.cdb_src !== 2'd2) begin
            n_fail++;
            $display("FAIL store_stream[%0d]: src=%0d pkt=%h, expected src=2 pkt=%h", i, bus.cdb_src, bus.cdb_packet, exp_cdb());
         end
         n_tests++;
         if (bus.src_stall !== 4'b0000 || bus.overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL store_stall[%0d]: stall=%b ovf=%b, expected 0000/0", i, bus.src_stall, bus.overflow);
         end
         step();
      end
      n_tests++;
      if (bus.cdb_packet.valid !== 1'b0) begin
         n_fail++;
         $display("FAIL store_idle: valid=%b, expected 0", bus.cdb_packet.valid);
      end
   endtask

   task automatic test_full_swap();
      // ALU and MULT both fill to DEPTH; a full FIFO granted while pushed keeps both.
      for (int c = 0; c < 7; c++) begin
         present(int'(CDB_ALU));
         present(int'(CDB_MULT));
         n_tests++;
         if (bus.cdb_packet !== exp_cdb() || bus.cdb_src !== exp_src()) begin
            n_fail++;
            $display("FAIL swap_cdb[%0d]: src=%0d pkt=%h, expected src=%0d pkt=%h", c, bus.cdb_src, bus.cdb_packet, exp_src(), exp_cdb());
         end
         n_tests++;
         if (bus.src_stall !== exp_stall() || bus.overflow !== m_ovf) begin
            n_fail++;
            $display("FAIL swap_stall[%0d]: stall=%b ovf=%b, expected %b/%b", c, bus.src_stall, bus.overflow, exp_stall(), m_ovf);
         end
         step();
      end
      clear_inputs();
      n_tests++;
      if (bus.src_stall !== 4'b0011 || bus.overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL swap_full: stall=%b ovf=%b, expected 0011/0", bus.src_stall, bus.overflow);
      end
      for (int c = 0; c < 40 && m_winner() >= 0; c++) begin
         n_tests++;
         if (bus.cdb_packet !== exp_cdb() || bus.cdb_src !== exp_src()) begin
            n_fail++;
            $display("FAIL swap_drain[%0d]: src=%0d pkt=%h, expected src=%0d pkt=%h", c, bus.cdb_src, bus.cdb_packet, exp_src(), exp_cdb());
         end
         step();
      end
      n_tests++;
      if (bus.cdb_packet.valid !== 1'b0 || bus.overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL swap_end: valid=%b ovf=%b, expected 0/0", bus.cdb_packet.valid, bus.overflow);
      end
   endtask

   task automatic test_flush();
      for (int c = 0; c < 5; c++) begin
         present(int'(CDB_MULT));
         present(int'(CDB_STORE));
         n_tests++;
         if (bus.cdb_packet !== exp_cdb() || bus.cdb_src !== exp_src()) begin
            n_fail++;
            $display("FAIL flush_fill[%0d]: src=%0d pkt=%h, expected src=%0d pkt=%h", c, bus.cdb_src, bus.cdb_packet, exp_src(), exp_cdb());
         end
         step();
      end
      clear_inputs();
      bus.flush = 1'b1;
      present(int'(CDB_LOAD));
      n_tests++;
      if (bus.cdb_packet !== exp_cdb() || bus.cdb_src !== exp_src() || bus.src_stall !== exp_stall()) begin
         n_fail++;
         $display("FAIL flush_cycle: src=%0d pkt=%h stall=%b, expected src=%0d pkt=%h stall=%b",
                  bus.cdb_src, bus.cdb_packet, bus.src_stall, exp_src(), exp_cdb(), exp_stall());
      end
      step();
      clear_inputs();
      n_tests++;
      if (bus.cdb_packet !== '0 || bus.cdb_src !== 2'd0 || bus.src_stall !== 4'b0000 || bus.overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_empty: src=%0d pkt=%h stall=%b ovf=%b, expected all zero",
                  bus.cdb_src, bus.cdb_packet, bus.src_stall, bus.overflow);
      end
      present(int'(CDB_ALU));
      present(int'(CDB_STORE));
      step();
      clear_inputs();
      for (int k = 0; k < 2; k++) begin
         n_tests++;
         if (bus.cdb_packet !== exp_cdb() || bus.cdb_src !== exp_src()) begin
            n_fail++;
            $display("FAIL flush_rr[%0d]: src=%0d pkt=%h, expected src=%0d pkt=%h", k, bus.cdb_src, bus.cdb_packet, exp_src(), exp_cdb());
         end
         step();
      end
   endtask

   task automatic test_backlog_overflow();
      for (int c = 0; c < 12; c++) begin
         for (int i = 0; i < N; i++) present(i);
         n_tests++;
         if (bus.cdb_packet !== exp_cdb() || bus.cdb_src !== exp_src()) begin
            n_fail++;
            $display("FAIL backlog_cdb[%0d]: src=%0d pkt=%h, expected src=%0d pkt=%h", c, bus.cdb_src, bus.cdb_packet, exp_src(), exp_cdb());
         end
         n_tests++;
         if (bus.src_stall !== exp_stall() || bus.overflow !== m_ovf) begin
            n_fail++;
            $display("FAIL backlog_stall[%0d]: stall=%b ovf=%b, expected %b/%b", c, bus.src_stall, bus.overflow, exp_stall(), m_ovf);
         end
         step();
      end
      clear_inputs();
      for (int c = 0; c < 40 && m_winner() >= 0; c++) begin
         n_tests++;
         if (bus.cdb_packet !== exp_cdb() || bus.cdb_src !== exp_src()) begin
            n_fail++;
            $display("FAIL backlog_drain[%0d]: src=%0d pkt=%h, expected src=%0d pkt=%h", c, bus.cdb_src, bus.cdb_packet, exp_src(), exp_cdb());
         end
         step();
      end
      n_tests++;
      if (bus.cdb_packet.valid !== 1'b0 || bus.overflow !== 1'b1) begin
         n_fail++;
         $display("FAIL backlog_end: valid=%b ovf=%b, expected 0/1", bus.cdb_packet.valid, bus.overflow);
      end
   endtask

   task automatic test_async_reset();
      present(int'(CDB_ALU));
      present(int'(CDB_MULT));
      present(int'(CDB_STORE));
      step();
      step();
      clear_inputs();
      #2;
      reset = 1'b0;
      #1;
      model_reset();
      n_tests++;
      if (bus.cdb_packet !== '0 || bus.cdb_src !== 2'd0 || bus.src_stall !== 4'b0000 || bus.overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset: src=%0d pkt=%h stall=%b ovf=%b, expected all zero",
                  bus.cdb_src, bus.cdb_packet, bus.src_stall, bus.overflow);
      end
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;
      n_tests++;
      if (bus.cdb_packet.valid !== 1'b0) begin
         n_fail++;
         $display("FAIL post_reset_idle: valid=%b, expected 0", bus.cdb_packet.valid);
      end
      present(int'(CDB_ALU));
      step();
      clear_inputs();
      n_tests++;
      if (bus.cdb_packet !== exp_cdb() || bus.cdb_src !== 2'd0 || bus.cdb_packet.valid !== 1'b1) begin
         n_fail++;
         $display("FAIL post_reset_alu: src=%0d pkt=%h, expected src=0 pkt=%h", bus.cdb_src, bus.cdb_packet, exp_cdb());
      end
      step();
      n_tests++;
      if (bus.cdb_packet.valid !== 1'b0) begin
         n_fail++;
         $display("FAIL post_reset_end: valid=%b, expected 0", bus.cdb_packet.valid);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached before the summary");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single_alu();
      test_all_sources();
      test_store_stream();
      test_full_swap();
      test_flush();
      test_backlog_overflow();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
